// File: rtl/cam_scale_up_out_buf.sv
// Skid FIFO behind the 2x scale-up stage: absorbs late beats, re-issues them on a
// strict valid/ready interface, and tags the head beat with end-of-line/frame.
module cam_scale_up_out_buf #(
  parameter int P_DEPTH          = 8,
  parameter int FIFO_DEPTH       = 16,
  parameter int SLACK            = 4,
  parameter int OUT_FRAME_WIDTH  = 1080,
  parameter int OUT_FRAME_HEIGHT = 960
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*P_DEPTH-1:0] in_red,
  input  logic [2*P_DEPTH-1:0] in_green,
  input  logic [2*P_DEPTH-1:0] in_blue,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*P_DEPTH-1:0] out_red,
  output logic [2*P_DEPTH-1:0] out_green,
  output logic [2*P_DEPTH-1:0] out_blue,
  output logic                 out_eol,
  output logic                 out_eof,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overflow
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int DW  = 6 * P_DEPTH;
  localparam int BPL = OUT_FRAME_WIDTH / 2;
  localparam int BW  = (BPL > 1) ? $clog2(BPL) : 1;
  localparam int LW  = (OUT_FRAME_HEIGHT > 1) ? $clog2(OUT_FRAME_HEIGHT) : 1;

  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] SLACK_C   = CW'(SLACK);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BPL - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(OUT_FRAME_HEIGHT - 1);

  logic [DW-1:0] mem_q [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [LW-1:0] line_cnt_q, line_cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          overflow_q, overflow_d;
  logic          wr, rd;

  assign out_valid = (count_q != '0);
  assign rd        = out_valid & out_ready;
  // A read frees the head slot in the same cycle, so a full FIFO still accepts.
  assign wr        = in_valid & ((count_q < FULL) | rd);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    beat_cnt_d = beat_cnt_q;
    line_cnt_d = line_cnt_q;
    overflow_d = overflow_q | (in_valid & ~wr);

    if (wr) wr_ptr_d = wr_ptr_q + AW'(1);

    if (rd) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      if (beat_cnt_q == BEAT_LAST) begin
        beat_cnt_d = '0;
        line_cnt_d = (line_cnt_q == LINE_LAST) ? '0 : line_cnt_q + LW'(1);
      end else begin
        beat_cnt_d = beat_cnt_q + BW'(1);
      end
    end

    case ({wr, rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    in_ready_d = (FULL - count_d) > SLACK_C;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beat_cnt_q <= '0;
      line_cnt_q <= '0;
      in_ready_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      beat_cnt_q <= beat_cnt_d;
      line_cnt_q <= line_cnt_d;
      in_ready_q <= in_ready_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr && !rst) mem_q[wr_ptr_q] <= {in_red, in_green, in_blue};
  end

  assign {out_red, out_green, out_blue} = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_eol  = out_valid & (beat_cnt_q == BEAT_LAST);
  assign out_eof  = out_eol & (line_cnt_q == LINE_LAST);
  assign in_ready = in_ready_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_cam_scale_up_out_buf.sv
// Bench for cam_scale_up_out_buf: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_cam_scale_up_out_buf;

  localparam int FD  = 16;
  localparam int SL  = 4;
  localparam int BPL = 4;
  localparam int BPF = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_red = '0, in_green = '0, in_blue = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_red, out_green, out_blue;
  logic        out_eol, out_eof, out_valid;
  logic        out_ready = 1'b0;
  logic        overflow;

  cam_scale_up_out_buf #(
    .P_DEPTH(8), .FIFO_DEPTH(FD), .SLACK(SL),
    .OUT_FRAME_WIDTH(8), .OUT_FRAME_HEIGHT(2)
  ) dut (
    .clk(clk), .rst(rst),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
    .out_eol(out_eol), .out_eof(out_eof), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [47:0] m_q[$];
  int          m_rd  = 0;
  logic        m_ovf = 1'b0;
  logic        m_ir  = 1'b0;
  logic        chk_en = 1'b0;

  int          rec_idx = 0;
  logic [15:0] eol_seen = '0;
  logic [15:0] eof_seen = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] rnd48();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[47:0];
  endfunction

  // One clock: drive at negedge, check the model, advance the model, move to next negedge.
  task automatic cycle(input logic r, input logic iv, input logic [47:0] d, input logic ordy);
    logic ev, rd, wr;
    rst = r; in_valid = iv; {in_red, in_green, in_blue} = d; out_ready = ordy;
    #1;
    ev = (m_q.size() != 0);
    if (chk_en) begin
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("out_data", 64'({out_red, out_green, out_blue}), ev ? 64'(m_q[0]) : 64'h0);
      chk("out_eol", 64'(out_eol), 64'(ev && (m_rd % BPL == BPL - 1)));
      chk("out_eof", 64'(out_eof), 64'(ev && (m_rd % BPF == BPF - 1)));
      chk("in_ready", 64'(in_ready), 64'(m_ir));
      chk("overflow", 64'(overflow), 64'(m_ovf));
    end
    if (out_valid === 1'b1 && ordy && !r && rec_idx < 16) begin
      eol_seen[rec_idx] = out_eol;
      eof_seen[rec_idx] = out_eof;
      rec_idx++;
    end
    if (r) begin
      m_q.delete(); m_rd = 0; m_ovf = 1'b0; m_ir = 1'b0;
    end else begin
      rd = ev && ordy;
      wr = iv && (m_q.size() < FD || rd);
      if (rd) begin void'(m_q.pop_front()); m_rd++; end
      if (wr) m_q.push_back(d);
      if (iv && !wr) m_ovf = 1'b1;
      m_ir = (FD - m_q.size()) > SL;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && m_q.size() != 0; i++) cycle(1'b0, 1'b0, 48'h0, 1'b1);
    cycle(1'b0, 1'b0, 48'h0, 1'b1);
    chk("drained", 64'(out_valid), 64'h0);
  endtask

  initial begin
    @(negedge clk);
    // Reset and idle
    cycle(1'b1, 1'b0, 48'h0, 1'b0);
    chk_en = 1'b1;
    cycle(1'b1, 1'b0, 48'h0, 1'b0);
    cycle(1'b1, 1'b0, 48'h0, 1'b0);
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    cycle(1'b0, 1'b0, 48'h0, 1'b0);
    chk("idle_in_ready", 64'(in_ready), 64'h1);
    chk("idle_out_valid", 64'(out_valid), 64'h0);
    chk("idle_overflow", 64'(overflow), 64'h0);

    // Passthrough
    cycle(1'b0, 1'b1, {16'hA5A5, 32'h0}, 1'b1);
    chk("pass_valid", 64'(out_valid), 64'h1);
    chk("pass_red", 64'(out_red), 64'hA5A5);
    cycle(1'b0, 1'b0, 48'h0, 1'b1);
    chk("pass_empty", 64'(out_valid), 64'h0);

    // Backpressure slack: 12 held drops in_ready, 3 late beats still stored
    cycle(1'b1, 1'b0, 48'h0, 1'b0);
    for (int i = 0; i < 11; i++) cycle(1'b0, 1'b1, rnd48(), 1'b0);
    chk("bp_ready_11", 64'(in_ready), 64'h1);
    cycle(1'b0, 1'b1, rnd48(), 1'b0);
    chk("bp_ready_12", 64'(in_ready), 64'h0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, rnd48(), 1'b0);
    chk("bp_held_15", 64'(m_q.size()), 64'd15);
    chk("bp_no_ovf", 64'(overflow), 64'h0);
    drain(20);

    // Overflow: 17 beats into a stalled FIFO
    cycle(1'b1, 1'b0, 48'h0, 1'b0);
    for (int i = 0; i < 17; i++) cycle(1'b0, 1'b1, rnd48(), 1'b0);
    chk("ovf_set", 64'(overflow), 64'h1);
    drain(20);
    chk("ovf_sticky", 64'(overflow), 64'h1);

    // Full with simultaneous read and write
    cycle(1'b1, 1'b0, 48'h0, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, rnd48(), 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, rnd48(), 1'b1);
    chk("full_rw_ovf", 64'(overflow), 64'h0);
    chk("full_rw_cnt", 64'(m_q.size()), 64'd16);
    drain(20);

    // Tagging: 16 beats = two 8-beat frames, random out_ready
    cycle(1'b1, 1'b0, 48'h0, 1'b0);
    rec_idx = 0; eol_seen = '0; eof_seen = '0;
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, rnd48(), 1'($urandom_range(0, 1)));
    drain(20);
    chk("tag_count", 64'(rec_idx), 64'd16);
    chk("tag_eol", 64'(eol_seen), 64'h8888);
    chk("tag_eof", 64'(eof_seen), 64'h8080);

    // Randomized traffic with occasional mid-stream reset
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0),
            rnd48(), 1'($urandom_range(0, 2) != 0));
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
